// File: rtl/simon_key_scheduler.sv
// SIMON round-key generator: loads an M-word master key and streams T round keys,
// deriving each new key word from a sliding M-word window.
module simon_key_scheduler #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int T  = 32,
    parameter int Cb = 5
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            abort,
    input  logic            key_valid,
    output logic            key_ready,
    input  logic [M*N-1:0]  key,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic [N-1:0]    rk,
    output logic [Cb-1:0]   rk_round,
    output logic            rk_last,
    output logic            busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [61:0]   Z    = 62'b01100111000011010100100010111110110011100001101010010001011111;
    localparam logic [Cb-1:0] LAST = Cb'(T - 1);

    state_t        state, state_next;
    logic [N-1:0]  w [M];
    logic [Cb-1:0] cnt;

    logic          load, advance;
    logic [5:0]    z_idx;
    logic          z_bit;
    logic [N-1:0]  t_rot, t_mix, f_word;

    assign key_ready = (state == IDLE) && !abort;
    assign rk_valid  = (state == RUN) && !abort;
    assign rk        = w[0];
    assign rk_round  = cnt;
    assign rk_last   = rk_valid && (cnt == LAST);
    assign busy      = (state == RUN);

    assign load    = key_valid && key_ready;
    assign advance = rk_valid && rk_ready && (cnt != LAST);

    // Next key word: the round constant bit only ever touches bit 0.
    always_comb begin
        z_idx  = 6'(int'(cnt) % 62);
        z_bit  = Z[z_idx];
        t_rot  = {w[M-1][2:0], w[M-1][N-1:3]};
        if (M == 4) t_rot = t_rot ^ w[1];
        t_mix  = t_rot ^ {t_rot[0], t_rot[N-1:1]};
        f_word = ~w[0] ^ t_mix ^ N'(3) ^ N'(z_bit);
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (key_valid) state_next = RUN;
                RUN:     if (rk_ready && cnt == LAST) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: the window is a handful of flops, not a RAM, so it is reset to give rk a defined value.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            cnt   <= '0;
            for (int j = 0; j < M; j++) w[j] <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                for (int j = 0; j < M; j++) w[j] <= key[j*N +: N];
                cnt <= '0;
            end else if (advance) begin
                for (int j = 0; j < M - 1; j++) w[j] <= w[j+1];
                w[M-1] <= f_word;
                cnt    <= cnt + Cb'(1);
            end
        end
    end

endmodule

// File: tb/tb_simon_key_scheduler.sv
// Directed bench for simon_key_scheduler: SIMON32/64-shaped instance plus an M=3, N=24 instance.
module tb_simon_key_scheduler;

    typedef struct {
        logic        rdy;
        logic [31:0] rk;
        int          round;
        logic        last;
    } vec_t;

    localparam logic [63:0] KEY64 = 64'h1918_1110_0908_0100;
    localparam logic [71:0] KEY72 = 72'h121110_0a0908_020100;
    localparam logic [61:0] ZC    = 62'b01100111000011010100100010111110110011100001101010010001011111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nReset;
    logic        abort, key_valid, rk_ready;
    logic [63:0] key;
    logic        key_ready, rk_valid, rk_last, busy;
    logic [15:0] rk;
    logic [4:0]  rk_round;

    logic        abort_b, key_valid_b, rk_ready_b;
    logic [71:0] key_b;
    logic        key_ready_b, rk_valid_b, rk_last_b, busy_b;
    logic [23:0] rk_b;
    logic [5:0]  rk_round_b;

    simon_key_scheduler #(.N(16), .M(4), .T(32), .Cb(5)) dut (
        .clk(clk), .nReset(nReset), .abort(abort), .key_valid(key_valid),
        .key_ready(key_ready), .key(key), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk(rk), .rk_round(rk_round), .rk_last(rk_last), .busy(busy)
    );

    simon_key_scheduler #(.N(24), .M(3), .T(36), .Cb(6)) dut48 (
        .clk(clk), .nReset(nReset), .abort(abort_b), .key_valid(key_valid_b),
        .key_ready(key_ready_b), .key(key_b), .rk_valid(rk_valid_b), .rk_ready(rk_ready_b),
        .rk(rk_b), .rk_round(rk_round_b), .rk_last(rk_last_b), .busy(busy_b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ks [64];
    vec_t        v32 [32];
    vec_t        v48 [36];
    logic [15:0] hand32 [5] = '{16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3};
    logic [23:0] hand48 [4] = '{24'h020100, 24'h0a0908, 24'h121110, 24'hFE9DCE};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Textbook array form of the key expansion: k[i] from k[i-1], k[i-3] and k[i-m].
    task automatic gen_ref(input int n, input int m, input int tt, input logic [95:0] mkey);
        logic [31:0] mask, tmp, r1;
        mask = (32'd1 << n) - 32'd1;
        for (int i = 0; i < m; i++) ks[i] = 32'(mkey >> (i * n)) & mask;
        for (int i = m; i < tt; i++) begin
            tmp = ((ks[i-1] >> 3) | (ks[i-1] << (n - 3))) & mask;
            if (m == 4) tmp = tmp ^ ks[i-3];
            r1  = ((tmp >> 1) | (tmp << (n - 1))) & mask;
            tmp = tmp ^ r1;
            ks[i] = (~ks[i-m] ^ tmp ^ 32'd3 ^ {31'd0, ZC[(i - m) % 62]}) & mask;
        end
    endtask

    initial begin
        int idx;

        gen_ref(16, 4, 32, 96'(KEY64));
        for (int i = 0; i < 32; i++) begin
            v32[i].rdy   = 1'b1;
            v32[i].rk    = (i < 5) ? 32'(hand32[i]) : ks[i];
            v32[i].round = i;
            v32[i].last  = (i == 31);
        end
        gen_ref(24, 3, 36, 96'(KEY72));
        for (int i = 0; i < 36; i++) begin
            v48[i].rdy   = 1'b1;
            v48[i].rk    = (i < 4) ? 32'(hand48[i]) : ks[i];
            v48[i].round = i;
            v48[i].last  = (i == 35);
        end

        nReset = 1'b0; abort = 1'b0; key_valid = 1'b0; rk_ready = 1'b0; key = '0;
        abort_b = 1'b0; key_valid_b = 1'b0; rk_ready_b = 1'b0; key_b = '0;

        #3;
        check("reset_rk_valid", 32'(rk_valid), 0);
        check("reset_rk", 32'(rk), 0);
        check("reset_rk_round", 32'(rk_round), 0);
        check("reset_rk_last", 32'(rk_last), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_key_ready", 32'(key_ready), 1);
        @(negedge clk);
        nReset = 1'b1;

        // Full schedule with the consumer always ready.
        key = KEY64; key_valid = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t1_valid[%0d]", i), 32'(rk_valid), 1);
            check($sformatf("t1_rk[%0d]", i), 32'(rk), v32[i].rk);
            check($sformatf("t1_round[%0d]", i), 32'(rk_round), 32'(v32[i].round));
            check($sformatf("t1_last[%0d]", i), 32'(rk_last), 32'(v32[i].last));
            rk_ready = v32[i].rdy;
            @(negedge clk);
        end
        check("t1_end_valid", 32'(rk_valid), 0);
        check("t1_end_key_ready", 32'(key_ready), 1);
        check("t1_end_busy", 32'(busy), 0);

        // Random backpressure, with a different key held valid throughout the run.
        key = KEY64; key_valid = 1'b1;
        @(negedge clk);
        key = 64'hDEAD_BEEF_CAFE_F00D;
        idx = 0;
        for (int c = 0; c < 400 && idx < 32; c++) begin
            check($sformatf("t2_valid[%0d]", idx), 32'(rk_valid), 1);
            check($sformatf("t2_rk[%0d]", idx), 32'(rk), v32[idx].rk);
            check($sformatf("t2_round[%0d]", idx), 32'(rk_round), 32'(v32[idx].round));
            check($sformatf("t2_last[%0d]", idx), 32'(rk_last), 32'(v32[idx].last));
            check($sformatf("t2_key_ready[%0d]", idx), 32'(key_ready), 0);
            rk_ready = 1'($urandom_range(0, 1));
            if (rk_ready) idx++;
            @(negedge clk);
        end
        check("t2_all_keys", 32'(idx), 32);
        check("t2_bubble_valid", 32'(rk_valid), 0);
        check("t2_bubble_key_ready", 32'(key_ready), 1);

        // Held key_valid loads at the edge right after the bubble; run to round 10, then abort.
        key = KEY64; rk_ready = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_rk[%0d]", i), 32'(rk), v32[i].rk);
            check($sformatf("t3_round[%0d]", i), 32'(rk_round), 32'(i));
            @(negedge clk);
        end
        check("t3_rk[10]", 32'(rk), v32[10].rk);
        check("t3_round[10]", 32'(rk_round), 10);
        abort = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        check("abort_rk_valid", 32'(rk_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_cnt_held", 32'(rk_round), 10);
        abort = 1'b0;
        #1;
        check("abort_key_ready", 32'(key_ready), 1);

        // All-zero key: rounds 0..3 are zero, round 4 is ~0 ^ 3 ^ z(0).
        key = '0; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("zero_valid", 32'(rk_valid), 1);
        check("zero_round0", 32'(rk_round), 0);
        check("zero_rk0", 32'(rk), 0);
        repeat (4) @(negedge clk);
        check("zero_round4", 32'(rk_round), 4);
        check("zero_rk4", 32'(rk), 32'h0000_FFFD);
        @(negedge clk);
        check("zero_round5", 32'(rk_round), 5);

        // Asynchronous reset in the middle of a cycle.
        #2 nReset = 1'b0;
        #1;
        check("areset_rk_valid", 32'(rk_valid), 0);
        check("areset_rk", 32'(rk), 0);
        check("areset_rk_round", 32'(rk_round), 0);
        check("areset_rk_last", 32'(rk_last), 0);
        check("areset_busy", 32'(busy), 0);
        check("areset_key_ready", 32'(key_ready), 1);
        @(negedge clk);
        nReset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_valid[%0d]", i), 32'(rk_valid), 0);
        end

        // M = 3, N = 24, T = 36 instance.
        key_b = KEY72; key_valid_b = 1'b1; rk_ready_b = 1'b1;
        @(negedge clk);
        key_valid_b = 1'b0;
        for (int i = 0; i < 36; i++) begin
            check($sformatf("s48_valid[%0d]", i), 32'(rk_valid_b), 1);
            check($sformatf("s48_rk[%0d]", i), 32'(rk_b), v48[i].rk);
            check($sformatf("s48_round[%0d]", i), 32'(rk_round_b), 32'(v48[i].round));
            check($sformatf("s48_last[%0d]", i), 32'(rk_last_b), 32'(v48[i].last));
            rk_ready_b = v48[i].rdy;
            @(negedge clk);
        end
        check("s48_end_valid", 32'(rk_valid_b), 0);
        check("s48_end_key_ready", 32'(key_ready_b), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
